// File: rtl/btb_pkg.sv
// Shared types for the BTB update scheduler.
//   btb_uq_entry_t : one queued BTB write, word-aligned pc and target
//   BTB_PC_W       : stored pc/target width (bits [31:2])
package btb_pkg;
  localparam int BTB_PC_W = 30;

  typedef struct packed {
    logic [BTB_PC_W-1:0] pc;
    logic [BTB_PC_W-1:0] target;
  } btb_uq_entry_t;
endpackage

// File: rtl/btb_update_queue.sv
// Coalescing FIFO of resolved branches waiting for a free BTB port cycle.
//   clk, rst        : clock, synchronous active-high reset
//   enq_i           : resolution this cycle (coalesce or allocate)
//   enq_pc_i/tgt_i  : resolution pc/target, word address
//   deq_i           : head is written to the BTB this cycle
//   hit_any_o       : enq pc matches some valid entry, head included
//   head_pc_o/tgt_o : head entry contents
//   count_o         : occupied entries
module btb_update_queue
  import btb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enq_i,
  input  logic [BTB_PC_W-1:0] enq_pc_i,
  input  logic [BTB_PC_W-1:0] enq_tgt_i,
  input  logic                deq_i,
  output logic                hit_any_o,
  output logic [BTB_PC_W-1:0] head_pc_o,
  output logic [BTB_PC_W-1:0] head_tgt_o,
  output logic [CW-1:0]       count_o
);
  btb_uq_entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [DEPTH-1:0]          vld_q, vld_d;
  logic [PW-1:0]             head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]             count_q, count_d;

  logic [DEPTH-1:0] match, coal_vec;
  logic             hit, alloc;

  always_comb begin
    match    = '0;
    coal_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = vld_q[i] && (ent_q[i].pc == enq_pc_i);
      // A head being drained this cycle already carries its old target to
      // the BTB, so it must not absorb the new one; allocate instead.
      coal_vec[i] = match[i] && !(deq_i && (PW'(i) == head_q));
    end
    hit_any_o = enq_i && (|match);
    hit       = enq_i && (|coal_vec);
    alloc     = enq_i && !hit;
  end

  always_comb begin
    ent_d   = ent_q;
    vld_d   = vld_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CW'(alloc) - CW'(deq_i);
    if (deq_i) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PW'(1);
    end
    if (enq_i) begin
      for (int i = 0; i < DEPTH; i++)
        if (coal_vec[i]) ent_d[i].target = enq_tgt_i;
    end
    // Allocation after dequeue: when full, the tail slot is the one just freed.
    if (alloc) begin
      ent_d[tail_q] = '{pc: enq_pc_i, target: enq_tgt_i};
      vld_d[tail_q] = 1'b1;
      tail_d        = tail_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q   <= '0;
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      vld_q   <= vld_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_pc_o  = ent_q[head_q].pc;
  assign head_tgt_o = ent_q[head_q].target;
  assign count_o    = count_q;
endmodule

// File: rtl/btb_update_sched.sv
// Arbitrates the single BTB port between fetch lookups and queued
// branch-resolution writes. Fetch wins unless the queue is full with a new
// non-coalescing resolution arriving, or the head has waited STARVE_LIM
// cycles; then fetch is stalled for one cycle while the head drains.
//   clk, rst                     : clock, synchronous active-high reset
//   res_valid/res_pc/res_target  : resolved-taken branch from back end
//   fe_fetch/fe_fetch_pc         : front-end lookup request
//   fe_stall                     : lookup not issued, hold and retry
//   btb_fetch/btb_fetch_pc       : BTB read port
//   btb_update/btb_pc/btb_target : BTB write port
//   uq_count                     : queued updates
module btb_update_sched
  import btb_pkg::*;
#(
  parameter int UQ_DEPTH   = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      res_valid,
  input  logic [31:0]               res_pc,
  input  logic [31:0]               res_target,
  input  logic                      fe_fetch,
  input  logic [31:0]               fe_fetch_pc,
  output logic                      fe_stall,
  output logic                      btb_fetch,
  output logic [31:0]               btb_fetch_pc,
  output logic                      btb_update,
  output logic [31:0]               btb_pc,
  output logic [31:0]               btb_target,
  output logic [$clog2(UQ_DEPTH):0] uq_count
);
  localparam int CW = $clog2(UQ_DEPTH) + 1;

  logic [7:0]          age_q, age_d;
  logic                deq, hit_any, force_drain, q_full, q_nempty;
  logic [BTB_PC_W-1:0] head_pc, head_tgt;
  logic [CW-1:0]       count;

  btb_update_queue #(.DEPTH(UQ_DEPTH)) u_uq (
    .clk        (clk),
    .rst        (rst),
    .enq_i      (res_valid),
    .enq_pc_i   (res_pc[31:2]),
    .enq_tgt_i  (res_target[31:2]),
    .deq_i      (deq),
    .hit_any_o  (hit_any),
    .head_pc_o  (head_pc),
    .head_tgt_o (head_tgt),
    .count_o    (count)
  );

  assign q_full   = (count == CW'(UQ_DEPTH));
  assign q_nempty = (count != '0);

  // The full-queue term uses the head-inclusive hit: a hit only on a head
  // that is drained anyway allocates into the slot the drain frees.
  assign force_drain = (q_full && res_valid && !hit_any) ||
                       (q_nempty && (age_q >= 8'(STARVE_LIM)));

  always_comb begin
    deq       = 1'b0;
    btb_fetch = 1'b0;
    fe_stall  = 1'b0;
    if (force_drain) begin
      deq      = 1'b1;
      fe_stall = fe_fetch;
    end else if (fe_fetch) begin
      btb_fetch = 1'b1;
    end else if (q_nempty) begin
      deq = 1'b1;
    end
  end

  // Age of the current head; saturates so the starvation compare stays valid.
  always_comb begin
    age_d = age_q;
    if (deq || !q_nempty)              age_d = '0;
    else if (age_q < 8'(STARVE_LIM))   age_d = age_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) age_q <= '0;
    else     age_q <= age_d;
  end

  assign btb_fetch_pc = fe_fetch_pc;
  assign btb_update   = deq;
  assign btb_pc       = {head_pc, 2'b00};
  assign btb_target   = {head_tgt, 2'b00};
  assign uq_count     = count;

  a_port_excl: assert property (@(posedge clk) disable iff (rst)
                                !(btb_fetch && btb_update));
endmodule

// File: tb/tb_btb_update_sched.sv
module tb_btb_update_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid;
  logic [31:0] res_pc, res_target;
  logic        fe_fetch;
  logic [31:0] fe_fetch_pc;
  logic        fe_stall, btb_fetch, btb_update;
  logic [31:0] btb_fetch_pc, btb_pc, btb_target;
  logic [2:0]  uq_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  btb_update_sched #(.UQ_DEPTH(4), .STARVE_LIM(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .res_valid    (res_valid),
    .res_pc       (res_pc),
    .res_target   (res_target),
    .fe_fetch     (fe_fetch),
    .fe_fetch_pc  (fe_fetch_pc),
    .fe_stall     (fe_stall),
    .btb_fetch    (btb_fetch),
    .btb_fetch_pc (btb_fetch_pc),
    .btb_update   (btb_update),
    .btb_pc       (btb_pc),
    .btb_target   (btb_target),
    .uq_count     (uq_count)
  );

  // Apply one cycle of inputs at the falling edge, settle, leave for checks.
  task automatic drive(input logic f, input logic [31:0] fpc,
                       input logic rv, input logic [31:0] rpc,
                       input logic [31:0] rtgt);
    @(negedge clk);
    fe_fetch    = f;
    fe_fetch_pc = fpc;
    res_valid   = rv;
    res_pc      = rpc;
    res_target  = rtgt;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(0, 0, 0, 0, 0);
    total++; if (uq_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", uq_count); end
    total++; if ({btb_update, btb_fetch, fe_stall} !== 3'b000) begin bad++;
      $display("FAIL reset_idle got=%b exp=000", {btb_update, btb_fetch, fe_stall}); end
  endtask

  task automatic test_idle_drain();
    do_reset();
    drive(0, 0, 1, 32'h100, 32'h200);
    total++; if (btb_update !== 1'b0) begin bad++; $display("FAIL idle_same_cycle got=%b exp=0", btb_update); end
    drive(0, 0, 0, 0, 0);
    total++; if ({btb_update, btb_pc, btb_target, uq_count} !== {1'b1, 32'h100, 32'h200, 3'd1}) begin bad++;
      $display("FAIL idle_drain got=%b %h %h %0d exp=1 100 200 1", btb_update, btb_pc, btb_target, uq_count); end
    drive(0, 0, 0, 0, 0);
    total++; if ({btb_update, uq_count} !== {1'b0, 3'd0}) begin bad++;
      $display("FAIL idle_after got=%b %0d exp=0 0", btb_update, uq_count); end
  endtask

  task automatic test_fetch_priority();
    do_reset();
    drive(1, 32'h1000, 1, 32'h40, 32'h80);
    total++; if ({btb_fetch, btb_fetch_pc, fe_stall, uq_count} !== {1'b1, 32'h1000, 1'b0, 3'd0}) begin bad++;
      $display("FAIL fp_first got=%b %h %b %0d exp=1 1000 0 0", btb_fetch, btb_fetch_pc, fe_stall, uq_count); end
    for (int c = 1; c <= 8; c++) begin
      drive(1, 32'h1000 + 32'(c * 4), 0, 0, 0);
      total++; if ({btb_fetch, fe_stall, btb_update, uq_count} !== {3'b100, 3'd1}) begin bad++;
        $display("FAIL fp_wait c=%0d got=%b%b%b %0d exp=100 1", c, btb_fetch, fe_stall, btb_update, uq_count); end
    end
    drive(1, 32'h1100, 0, 0, 0);
    total++; if ({btb_update, btb_fetch, fe_stall, btb_pc, btb_target} !== {3'b101, 32'h40, 32'h80}) begin bad++;
      $display("FAIL fp_starve got=%b%b%b %h %h exp=101 40 80", btb_update, btb_fetch, fe_stall, btb_pc, btb_target); end
    drive(1, 32'h1104, 0, 0, 0);
    total++; if ({btb_fetch, btb_update, fe_stall, uq_count} !== {3'b100, 3'd0}) begin bad++;
      $display("FAIL fp_resume got=%b%b%b %0d exp=100 0", btb_fetch, btb_update, fe_stall, uq_count); end
  endtask

  task automatic test_coalesce();
    do_reset();
    drive(1, 32'h2000, 1, 32'h80, 32'h300);
    drive(1, 32'h2004, 1, 32'h80, 32'h400);
    drive(1, 32'h2008, 0, 0, 0);
    total++; if (uq_count !== 3'd1) begin bad++; $display("FAIL coal_count got=%0d exp=1", uq_count); end
    drive(0, 0, 0, 0, 0);
    total++; if ({btb_update, btb_pc, btb_target} !== {1'b1, 32'h80, 32'h400}) begin bad++;
      $display("FAIL coal_drain got=%b %h %h exp=1 80 400", btb_update, btb_pc, btb_target); end
  endtask

  // Resolution matching a head that drains in the same cycle: old target goes
  // out now, new target gets its own entry.
  task automatic test_coalesce_head_drain();
    do_reset();
    drive(1, 32'h3000, 1, 32'h200, 32'h10);
    drive(0, 0, 1, 32'h200, 32'h20);
    total++; if ({btb_update, btb_target, uq_count} !== {1'b1, 32'h10, 3'd1}) begin bad++;
      $display("FAIL hd_old got=%b %h %0d exp=1 10 1", btb_update, btb_target, uq_count); end
    drive(0, 0, 0, 0, 0);
    total++; if ({btb_update, btb_pc, btb_target, uq_count} !== {1'b1, 32'h200, 32'h20, 3'd1}) begin bad++;
      $display("FAIL hd_new got=%b %h %h %0d exp=1 200 20 1", btb_update, btb_pc, btb_target, uq_count); end
    drive(0, 0, 0, 0, 0);
    total++; if (uq_count !== 3'd0) begin bad++; $display("FAIL hd_empty got=%0d exp=0", uq_count); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++)
      drive(1, 32'h5000, 1, 32'h1000 + 32'(i * 4), 32'h11000 + 32'(i * 4));
    drive(1, 32'h5000, 1, 32'h1010, 32'h11010);
    total++; if ({btb_update, btb_fetch, fe_stall, btb_pc, btb_target, uq_count} !==
                 {3'b101, 32'h1000, 32'h11000, 3'd4}) begin bad++;
      $display("FAIL full_force got=%b%b%b %h %h %0d exp=101 1000 11000 4",
               btb_update, btb_fetch, fe_stall, btb_pc, btb_target, uq_count); end
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 0, 0, 0);
      total++; if ({btb_update, btb_pc, btb_target, uq_count} !==
                   {1'b1, 32'h1000 + 32'(i * 4), 32'h11000 + 32'(i * 4), 3'(5 - i)}) begin bad++;
        $display("FAIL full_order i=%0d got=%b %h %h %0d", i, btb_update, btb_pc, btb_target, uq_count); end
    end
    drive(0, 0, 0, 0, 0);
    total++; if ({btb_update, uq_count} !== {1'b0, 3'd0}) begin bad++;
      $display("FAIL full_empty got=%b %0d exp=0 0", btb_update, uq_count); end
  endtask

  task automatic test_random();
    logic [31:0] exp_t [6];
    logic        exp_v [6];
    logic [31:0] wr_t  [6];
    logic        wr_v  [6];
    logic        f, rv;
    logic [31:0] tgt;
    int          idx, widx;
    int          guard;
    do_reset();
    for (int i = 0; i < 6; i++) begin exp_v[i] = 0; wr_v[i] = 0; exp_t[i] = 0; wr_t[i] = 0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      f   = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 9) < 4);
      idx = $urandom_range(0, 5);
      tgt = $urandom; tgt[1:0] = 2'b00;
      if (cyc % 600 == 300) begin
        rst = 1'b1;
        drive(f, 32'h9000, rv, 32'h4000 + 32'(idx * 4), tgt);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin exp_v[i] = 0; wr_v[i] = 0; end
        drive(0, 0, 0, 0, 0);
        total++; if ({uq_count, btb_update} !== {3'd0, 1'b0}) begin bad++;
          $display("FAIL rnd_rst got=%0d %b exp=0 0", uq_count, btb_update); end
        continue;
      end
      drive(f, 32'h9000 + 32'(cyc * 4), rv, 32'h4000 + 32'(idx * 4), tgt);
      total++; if ((btb_fetch && btb_update) || (fe_stall && !(fe_fetch && btb_update)) ||
                   (btb_fetch !== (fe_fetch && !fe_stall))) begin bad++;
        $display("FAIL rnd_port cyc=%0d fetch=%b upd=%b stall=%b fe=%b", cyc, btb_fetch, btb_update, fe_stall, fe_fetch); end
      if (btb_update) begin
        widx = int'((btb_pc - 32'h4000) >> 2);
        if (widx >= 0 && widx < 6) begin wr_v[widx] = 1; wr_t[widx] = btb_target; end
      end
      if (rv) begin exp_v[idx] = 1; exp_t[idx] = tgt; end
    end
    guard = 0;
    drive(0, 0, 0, 0, 0);
    while (uq_count != 0 && guard < 20) begin
      if (btb_update) begin
        widx = int'((btb_pc - 32'h4000) >> 2);
        if (widx >= 0 && widx < 6) begin wr_v[widx] = 1; wr_t[widx] = btb_target; end
      end
      drive(0, 0, 0, 0, 0);
      guard++;
    end
    total++; if (uq_count !== 3'd0) begin bad++; $display("FAIL rnd_drain_timeout count=%0d exp=0", uq_count); end
    for (int i = 0; i < 6; i++) begin
      if (exp_v[i]) begin
        total++; if (!wr_v[i] || wr_t[i] !== exp_t[i]) begin bad++;
          $display("FAIL rnd_sb pc=%h written=%b got=%h exp=%h", 32'h4000 + 32'(i * 4), wr_v[i], wr_t[i], exp_t[i]); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; res_valid = 0; res_pc = 0; res_target = 0; fe_fetch = 0; fe_fetch_pc = 0;
    test_reset();
    test_idle_drain();
    test_fetch_priority();
    test_coalesce();
    test_coalesce_head_drain();
    test_full();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
